// File: rtl/load_ext_if.sv
// load_ext_if: request/result handshake bundle for the load extender.
interface load_ext_if #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFF_W-1:0]  in_offset;
    logic [2:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_adel;

    modport master (
        output flush, in_valid, in_data, in_offset, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_adel
    );

    modport slave (
        input  flush, in_valid, in_data, in_offset, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_adel
    );
endinterface

// File: rtl/load_ext.sv
// load_ext: single registered stage that lane-selects and sign/zero-extends a load result.
module load_ext #(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input logic       clk,
    input logic       resetn,
    load_ext_if.slave bus
);
    logic              r_valid;
    logic              r_adel;
    logic [DATA_W-1:0] r_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_word;
    logic [DATA_W-1:0] w_ext;
    logic              w_adel;
    logic              w_acc;

    assign w_byte = bus.in_data[{bus.in_offset, 3'b000} +: 8];
    assign w_half = bus.in_data[{bus.in_offset[OFF_W-1:1], 4'b0000} +: 16];

    // a 32-bit path has only one word lane, so the word select collapses
    generate
        if (DATA_W == 64) begin : g_w64
            assign w_word = bus.in_data[{bus.in_offset[OFF_W-1], 5'b00000} +: 32];
        end else begin : g_w32
            assign w_word = bus.in_data[31:0];
        end
    endgenerate

    assign w_adel = (bus.in_mode[2:1] == 2'b01) ? bus.in_offset[0]
                  : (bus.in_mode[2:1] == 2'b10) ? |bus.in_offset[1:0]
                  : (bus.in_mode == 3'b110)     ? |bus.in_offset
                  : 1'b0;

    assign w_ext = (bus.in_mode[2:1] == 2'b00) ? (bus.in_mode[0] ? DATA_W'(w_byte) : DATA_W'($signed(w_byte)))
                 : (bus.in_mode[2:1] == 2'b01) ? (bus.in_mode[0] ? DATA_W'(w_half) : DATA_W'($signed(w_half)))
                 : (bus.in_mode[2:1] == 2'b10) ? (bus.in_mode[0] ? DATA_W'(w_word) : DATA_W'($signed(w_word)))
                 : bus.in_data;

    assign bus.in_ready  = !r_valid || bus.out_ready;
    assign w_acc         = bus.in_valid && bus.in_ready && !bus.flush;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_adel  = r_adel;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_adel  <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_adel ? '0 : w_ext;
            r_adel  <= w_adel;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule
